check_node: RTL and testbench
=============================

CHECK_NODE -- requirements
Module: check_node

Interface
REQ-001 SHALL have parameter weight, default 6: number of variable nodes connected to this check node (weight >= 2).
REQ-002 SHALL have parameter length, default 15: bit width of each message, two's complement.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port variable_value_input  input  weight*length  packed variable-to-check messages; edge i occupies bits [length*(i+1)-1 : length*i].
REQ-006 SHALL have port variable_enable_input  input  weight  bit i high = message i valid.
REQ-007 SHALL have port decision_down  input  1  decision complete; release outputs.
REQ-008 SHALL have port check_value_output  output  weight*length  packed check-to-variable messages, same packing as REQ-005.
REQ-009 SHALL have port check_enable  output  1  high = all check_value_output fields valid.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SCAN, HOLD.
REQ-011 IDLE: when all weight bits of variable_enable_input are high, SHALL register all weight input messages into an internal snapshot, clear the scan index, min1, min2 and parity, and enter SCAN. Otherwise SHALL remain in IDLE.
REQ-012 SCAN SHALL process exactly one snapshot message per cycle, index 0 to weight-1, taking weight cycles. It then enters HOLD.
REQ-013 Magnitude of a message SHALL be its absolute value. The most negative value -2^(length-1) SHALL saturate to 2^(length-1)-1.
REQ-014 Sign of a message SHALL be its MSB, so zero counts as non-negative. Parity SHALL be the XOR of all weight signs.
REQ-015 Per message m at index k: if m < min1 (strict), then min2 <= min1, min1 <= m, idx1 <= k. Else if m < min2, then min2 <= m. Initial values SHALL be min1 = min2 = 2^(length-1)-1.
REQ-016 Ties SHALL keep the lower index as idx1; an equal later magnitude SHALL go to min2.
REQ-017 On entering HOLD, output field i SHALL be formed as follows:
- magnitude = min2 if i == idx1, else min1;
- sign = parity XOR sign_i;
- value = negated magnitude if sign is 1, else the magnitude.
REQ-018 check_enable SHALL go high in the same cycle that output fields first become valid. Latency from the IDLE capture edge to check_enable high SHALL be weight+1 cycles.
REQ-019 Outputs SHALL be registered and remain stable for the whole HOLD state.
REQ-020 HOLD: when decision_down is high, SHALL clear check_enable and return to IDLE on that edge. check_value_output SHALL retain its last value.
REQ-021 decision_down SHALL be ignored in IDLE and SCAN.
REQ-022 Changes on variable_enable_input or variable_value_input during SCAN or HOLD SHALL be ignored, because the snapshot is used.
REQ-023 Re-entry from IDLE with enables still high SHALL start a new capture one cycle after HOLD exits.
REQ-024 Internal magnitude arithmetic SHALL be length-1 bits unsigned. No output SHALL ever equal -2^(length-1).

Reset
REQ-025 When rst is high at a clock edge: state becomes IDLE; check_enable = 0; check_value_output = 0; snapshot, min1, min2, idx1, parity and index are cleared.
REQ-026 rst SHALL override all other inputs, including mid-SCAN and mid-HOLD, with no partial output.
REQ-027 After reset is released, operation SHALL start only on a fresh all-enables-high condition.

Verification (weight=3, length=8)
REQ-028 Basic: inputs {5, -3, 7}, all enables high at cycle 0 -> at cycle 4, check_enable=1 and outputs {-3, +5, -3}. Outputs hold until decision_down.
REQ-029 Tie/zero: inputs {4, 4, 0} -> min1=0 at idx 2, min2=4 -> outputs {0, 0, +4}.
REQ-030 Saturation: inputs {-128, -100, 90} -> outputs {-90, -90, +100}. No output equals -128.
REQ-031 Partial enables: enables 3'b011 held for 10 cycles -> check_enable stays 0. Raising bit 2 -> check_enable high 4 cycles later.
REQ-032 Handshake: decision_down asserted during SCAN -> ignored. Asserted in HOLD -> check_enable low next edge. Enables kept high -> new result after 4 more cycles.
REQ-033 Reset mid-operation: rst high on the 2nd SCAN cycle -> all outputs 0 and state IDLE. After release with enables high -> correct result 4 cycles after capture.

Source files
------------

// File: rtl/check_node.sv
// Min-sum LDPC check node: snapshots all variable messages, scans them serially
// for min1/min2/parity, then holds the check-to-variable messages until released.
module check_node #(
    parameter int unsigned weight = 6,
    parameter int unsigned length = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [weight*length-1:0]   variable_value_input,
    input  logic [weight-1:0]          variable_enable_input,
    input  logic                       decision_down,
    output logic [weight*length-1:0]   check_value_output,
    output logic                       check_enable
);

    localparam int unsigned MAG_W = length - 1;
    localparam int unsigned IDX_W = $clog2(weight + 1);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    state_t                  state_q;
    logic [length-1:0]       snap_q [weight];
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx1_q;
    logic [MAG_W-1:0]        min1_q;
    logic [MAG_W-1:0]        min2_q;
    logic                    parity_q;
    logic [weight*length-1:0] out_q;
    logic                    en_q;

    logic [length-1:0]        cur_msg;
    logic [MAG_W-1:0]         cur_mag;
    logic                     cur_sgn;
    logic [weight*length-1:0] out_d;
    logic [MAG_W-1:0]         fld_mag;
    logic [length-1:0]        fld_ext;
    logic                     fld_sgn;

    // Absolute value; the most negative code saturates to the largest magnitude.
    function automatic logic [MAG_W-1:0] mag_of(input logic [length-1:0] m);
        logic [length-1:0] neg;
        neg = -m;
        if (!m[length-1]) begin
            return m[MAG_W-1:0];
        end
        if (m[MAG_W-1:0] == '0) begin
            return MAG_MAX;
        end
        return neg[MAG_W-1:0];
    endfunction

    always_comb begin
        cur_msg = '0;
        for (int k = 0; k < weight; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_msg = snap_q[k];
            end
        end
    end

    assign cur_mag = mag_of(cur_msg);
    assign cur_sgn = cur_msg[length-1];

    // Output edge i excludes itself: it sees min2 only when it owns min1.
    always_comb begin
        out_d   = '0;
        fld_mag = '0;
        fld_ext = '0;
        fld_sgn = 1'b0;
        for (int i = 0; i < weight; i++) begin
            fld_mag = (IDX_W'(i) == idx1_q) ? min2_q : min1_q;
            fld_sgn = parity_q ^ snap_q[i][length-1];
            fld_ext = {1'b0, fld_mag};
            out_d[i*length +: length] = fld_sgn ? -fld_ext : fld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            idx1_q   <= '0;
            min1_q   <= '0;
            min2_q   <= '0;
            parity_q <= 1'b0;
            out_q    <= '0;
            en_q     <= 1'b0;
            for (int k = 0; k < weight; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (&variable_enable_input) begin
                        for (int k = 0; k < weight; k++) begin
                            snap_q[k] <= variable_value_input[k*length +: length];
                        end
                        idx_q    <= '0;
                        idx1_q   <= '0;
                        min1_q   <= MAG_MAX;
                        min2_q   <= MAG_MAX;
                        parity_q <= 1'b0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    // Extra cycle after the last message lets the finished minima settle into outputs.
                    if (idx_q == IDX_W'(weight)) begin
                        out_q   <= out_d;
                        en_q    <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        if (cur_mag < min1_q) begin
                            min2_q <= min1_q;
                            min1_q <= cur_mag;
                            idx1_q <= idx_q;
                        end else if (cur_mag < min2_q) begin
                            min2_q <= cur_mag;
                        end
                        parity_q <= parity_q ^ cur_sgn;
                        idx_q    <= idx_q + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (decision_down) begin
                        en_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign check_value_output = out_q;
    assign check_enable       = en_q;

endmodule

// File: tb/tb_check_node.sv
// Directed bench for check_node (weight=3, length=8) with a min-sum reference
// model feeding an expected-result queue.
module tb_check_node;

    localparam int unsigned W = 3;
    localparam int unsigned L = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W*L-1:0] vin;
    logic [W-1:0]   ven;
    logic           dd;
    logic [W*L-1:0] cvo;
    logic           ce;

    int             checks = 0;
    int             errors = 0;
    logic [W*L-1:0] sb [$];
    logic [W*L-1:0] last_exp;

    always #5 clk = ~clk;

    check_node #(.weight(W), .length(L)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .variable_value_input  (vin),
        .variable_enable_input (ven),
        .decision_down         (dd),
        .check_value_output    (cvo),
        .check_enable          (ce)
    );

    // Reference: each output is the min magnitude and sign product over the other edges.
    function automatic logic [W*L-1:0] model(input logic signed [L-1:0] a,
                                             input logic signed [L-1:0] b,
                                             input logic signed [L-1:0] c);
        logic signed [L-1:0] v [W];
        int                  mag [W];
        logic [W*L-1:0]      res;
        int                  m;
        bit                  s;
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < W; i++) begin
            if (v[i] == -128) mag[i] = 127;
            else if (v[i] < 0) mag[i] = -int'(v[i]);
            else mag[i] = int'(v[i]);
        end
        res = '0;
        for (int i = 0; i < W; i++) begin
            m = 1000;
            s = 1'b0;
            for (int j = 0; j < W; j++) begin
                if (j != i) begin
                    if (mag[j] < m) m = mag[j];
                    s = s ^ (v[j] < 0);
                end
            end
            res[i*L +: L] = s ? L'(-m) : L'(m);
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [W*L-1:0] got, input logic [W*L-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic signed [L-1:0] a, input logic signed [L-1:0] b,
                         input logic signed [L-1:0] c, input bit push);
        vin = {c, b, a};
        ven = 3'b111;
        if (push) sb.push_back(model(a, b, c));
    endtask

    // n0 = negedges already elapsed since the capture edge.
    task automatic wait_result(input string tag, input int n0);
        int             n;
        logic [W*L-1:0] exp;
        n = n0;
        do begin
            @(negedge clk);
            n++;
        end while (ce !== 1'b1 && n < 20);
        check({tag, " latency"}, (W*L)'(n - 1), (W*L)'(4));
        exp = sb.pop_front();
        check({tag, " value"}, cvo, exp);
        last_exp = exp;
    endtask

    task automatic hold_stable(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            vin = (W*L)'($urandom);
            ven = W'($urandom);
            @(negedge clk);
            check({tag, " hold_en"}, (W*L)'(ce), (W*L)'(1));
            check({tag, " hold_val"}, cvo, last_exp);
        end
    endtask

    task automatic release_hold(input string tag, input bit keep);
        dd = 1'b1;
        if (!keep) ven = '0;
        @(negedge clk);
        check({tag, " ce_drop"}, (W*L)'(ce), '0);
        check({tag, " retain"}, cvo, last_exp);
        dd = 1'b0;
    endtask

    initial begin
        logic bad;
        rst = 1'b1;
        vin = '0;
        ven = '0;
        dd  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset ce", (W*L)'(ce), '0);
        check("reset val", cvo, '0);
        rst = 1'b0;

        // Basic result, also against the hand-derived fields {-3, +5, -3}.
        start(8'sd5, -8'sd3, 8'sd7, 1'b1);
        wait_result("basic", 0);
        check("basic const", cvo, 24'hFD05FD);
        hold_stable("basic", 3);
        release_hold("basic", 1'b0);

        // Tie and zero: {4,4,0} -> {0,0,+4}.
        start(8'sd4, 8'sd4, 8'sd0, 1'b1);
        wait_result("tie", 0);
        check("tie const", cvo, 24'h040000);
        release_hold("tie", 1'b0);

        // Saturation of -128: {-128,-100,90} -> {-90,-90,+100}.
        start(-8'sd128, -8'sd100, 8'sd90, 1'b1);
        wait_result("sat", 0);
        check("sat const", cvo, 24'h64A6A6);
        bad = (cvo[7:0] == 8'h80) || (cvo[15:8] == 8'h80) || (cvo[23:16] == 8'h80);
        check("sat no_min", (W*L)'(bad), '0);
        release_hold("sat", 1'b0);

        // Partial enables never start a scan.
        vin = {8'sd12, -8'sd9, 8'sd33};
        ven = 3'b011;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("partial idle", (W*L)'(ce), '0);
        end
        start(8'sd33, -8'sd9, 8'sd12, 1'b1);
        wait_result("partial", 0);
        release_hold("partial", 1'b0);

        // decision_down during SCAN is ignored; in HOLD it releases and re-captures.
        start(8'sd1, 8'sd2, -8'sd3, 1'b1);
        @(negedge clk);
        dd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dd = 1'b0;
        wait_result("hs scan", 3);
        start(-8'sd50, 8'sd60, -8'sd70, 1'b1);
        release_hold("hs", 1'b1);
        wait_result("hs again", 0);
        release_hold("hs again", 1'b0);

        // Reset on the second SCAN cycle clears everything.
        start(8'sd10, -8'sd20, 8'sd30, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ven = '0;
        @(negedge clk);
        check("rst scan ce", (W*L)'(ce), '0);
        check("rst scan val", cvo, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst idle ce", (W*L)'(ce), '0);
        start(8'sd10, -8'sd20, 8'sd30, 1'b1);
        wait_result("post rst", 0);
        check("post rst const", cvo, 24'hF60AEC);
        release_hold("post rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
